// File: rtl/image_frame_loader.sv
// Assembles a byte stream into a FRAME_BITS-wide image frame tagged with a destination approach.
// Bytes fill the frame MSB-first; a complete frame is presented for one cycle with frame_valid.
module image_frame_loader #(
  parameter int FRAME_BITS = 1024,
  parameter int NUM_DEST   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  input  logic                  in_sof,
  input  logic [2:0]            in_dest,
  output logic                  frame_valid,
  output logic [2:0]            frame_dest,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  err,
  output logic [15:0]           frame_count
);
  localparam int NBYTES = FRAME_BITS / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);
  localparam logic [3:0] DEST_LIM = 4'(NUM_DEST);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      byte_cnt, byte_cnt_nx;
  logic [2:0]            dest_q, dest_nx;
  logic                  live;
  logic                  accept, sof_ok;
  logic                  err_nx, emit_nx, wr_en;
  logic [CNT_W-1:0]      wr_slot, wr_idx;
  // The last byte bypasses this register straight into frame_data, so it holds NBYTES-1 bytes.
  logic [FRAME_BITS-9:0] shift;

  assign in_ready = live && (state != EMIT);
  assign accept   = in_valid && in_ready;
  assign sof_ok   = in_sof && ({1'b0, in_dest} < DEST_LIM);
  assign wr_idx   = LAST_IDX - CNT_W'(1) - wr_slot;

  always_comb begin
    state_nx    = state;
    byte_cnt_nx = byte_cnt;
    dest_nx     = dest_q;
    err_nx      = 1'b0;
    emit_nx     = 1'b0;
    wr_en       = 1'b0;
    wr_slot     = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (sof_ok) begin
            state_nx    = LOAD;
            dest_nx     = in_dest;
            wr_en       = 1'b1;
            byte_cnt_nx = CNT_W'(1);
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          if (in_sof) begin
            // A new SOF mid-frame aborts the partial frame and may start a fresh one.
            err_nx = 1'b1;
            if (sof_ok) begin
              dest_nx     = in_dest;
              wr_en       = 1'b1;
              byte_cnt_nx = CNT_W'(1);
            end else begin
              state_nx    = IDLE;
              byte_cnt_nx = '0;
            end
          end else if (byte_cnt == LAST_IDX) begin
            state_nx    = EMIT;
            byte_cnt_nx = '0;
            emit_nx     = 1'b1;
          end else begin
            wr_en       = 1'b1;
            wr_slot     = byte_cnt;
            byte_cnt_nx = byte_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      dest_q      <= '0;
      live        <= 1'b0;
      err         <= 1'b0;
      frame_valid <= 1'b0;
      frame_dest  <= '0;
      frame_data  <= '0;
      frame_count <= '0;
    end else begin
      state       <= state_nx;
      byte_cnt    <= byte_cnt_nx;
      dest_q      <= dest_nx;
      live        <= 1'b1;
      err         <= err_nx;
      frame_valid <= emit_nx;
      if (emit_nx) begin
        frame_data  <= {shift, in_data};
        frame_dest  <= dest_q;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) shift[{wr_idx, 3'b000} +: 8] <= in_data;
  end
endmodule
